// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, STATUS/CTRL bit indices and constants shared by uart_mmio.
package uart_mmio_pkg;
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_DROP   = 6;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_TX_FLUSH  = 2;
    localparam int CTRL_RX_FLUSH  = 3;

    localparam logic [31:0] RX_EMPTY_FLAG = 32'h8000_0000;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push accepted when not full or popping, flush wins.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART controller with TX/RX FIFOs, sticky errors and flush controls.
// Define UART_MMIO_IRQ_EN to add the registered irq output and CTRL interrupt enables.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int RX_FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_wr_en,
    input  logic                  bus_rd_en,
    input  logic [31:0]           bus_wdata,
    output logic [31:0]           bus_rdata,
    output logic                  bus_rvalid,
    output logic [DATA_WIDTH-1:0] tx_tdata,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    input  logic [DATA_WIDTH-1:0] rx_tdata,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    input  logic                  rx_frame_error,
    input  logic                  rx_overrun_error
`ifdef UART_MMIO_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int TCW = $clog2(TX_FIFO_DEPTH) + 1;
    localparam int RCW = $clog2(RX_FIFO_DEPTH) + 1;

    logic                  mapped;
    logic [1:0]            sel;
    logic                  wr_tx, wr_status, wr_ctrl, rd_rx;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_pop, rx_pop, rx_push, tx_flush, rx_flush;
    logic [TCW-1:0]        tx_count;
    logic [RCW-1:0]        rx_count;
    logic [DATA_WIDTH-1:0] rx_head;
    logic [2:0]            sticky, sticky_set, sticky_clr;
    logic [1:0]            irq_en;
    logic [31:0]           status, rd_val;
    logic                  unused;

    assign unused = ^{bus_addr[1:0], bus_wdata};

    assign mapped    = (bus_addr >> 4) == '0;
    assign sel       = bus_addr[3:2];
    assign wr_tx     = bus_wr_en && mapped && sel == REG_TXDATA;
    assign wr_status = bus_wr_en && mapped && sel == REG_STATUS;
    assign wr_ctrl   = bus_wr_en && mapped && sel == REG_CTRL;
    assign rd_rx     = bus_rd_en && mapped && sel == REG_RXDATA;

    assign tx_flush  = wr_ctrl && bus_wdata[CTRL_TX_FLUSH];
    assign rx_flush  = wr_ctrl && bus_wdata[CTRL_RX_FLUSH];
    assign tx_tvalid = !tx_empty;
    assign tx_pop    = tx_tvalid && tx_tready;
    assign rx_pop    = rd_rx && !rx_empty;
    // A full RX FIFO still takes a byte while firmware pops one in the same cycle.
    assign rx_tready = !rst && (!rx_full || rx_pop);
    assign rx_push   = rx_tvalid && rx_tready;

    assign sticky_set = {wr_tx && tx_full && !tx_pop, rx_frame_error, rx_overrun_error};
    assign sticky_clr = wr_status ? bus_wdata[ST_TX_DROP:ST_OVERRUN] : 3'b0;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .pop   (tx_pop),
        .flush (tx_flush),
        .wdata (bus_wdata[DATA_WIDTH-1:0]),
        .rdata (tx_tdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .wdata (rx_tdata),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_OVERRUN]   = sticky[0];
        status[ST_FRAME_ERR] = sticky[1];
        status[ST_TX_DROP]   = sticky[2];
        status[15:8]         = 8'(tx_count);
        status[23:16]        = 8'(rx_count);
    end

    always_comb begin
        rd_val = '0;
        if (mapped)
            case (sel)
                REG_RXDATA: rd_val = rx_empty ? RX_EMPTY_FLAG : 32'(rx_head);
                REG_STATUS: rd_val = status;
                REG_CTRL:   rd_val = 32'(irq_en);
                default:    rd_val = '0;
            endcase
    end

    // Set beats a same-cycle W1C clear so no error event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            sticky     <= '0;
        end else begin
            bus_rvalid <= bus_rd_en;
            if (bus_rd_en) bus_rdata <= rd_val;
            sticky <= sticky_set | (sticky & ~sticky_clr);
        end
    end

`ifdef UART_MMIO_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= bus_wdata[CTRL_TX_IRQ_EN:CTRL_RX_IRQ_EN];
            irq <= (irq_en[CTRL_RX_IRQ_EN] && !rx_empty) ||
                   (irq_en[CTRL_TX_IRQ_EN] && tx_empty) || |sticky;
        end
    end
`else
    assign irq_en = '0;
`endif
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed self-checking bench for uart_mmio (ADDR_WIDTH=5 to reach unmapped space).
module tb_uart_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  bus_addr = '0;
    logic        bus_wr_en = 1'b0;
    logic        bus_rd_en = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready = 1'b0;
    logic [7:0]  rx_tdata = '0;
    logic        rx_tvalid = 1'b0;
    logic        rx_tready;
    logic        rx_frame_error = 1'b0;
    logic        rx_overrun_error = 1'b0;
`ifdef UART_MMIO_IRQ_EN
    logic        irq;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_mmio #(.DATA_WIDTH(8), .TX_FIFO_DEPTH(16), .RX_FIFO_DEPTH(16), .ADDR_WIDTH(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_addr         (bus_addr),
        .bus_wr_en        (bus_wr_en),
        .bus_rd_en        (bus_rd_en),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .bus_rvalid       (bus_rvalid),
        .tx_tdata         (tx_tdata),
        .tx_tvalid        (tx_tvalid),
        .tx_tready        (tx_tready),
        .rx_tdata         (rx_tdata),
        .rx_tvalid        (rx_tvalid),
        .rx_tready        (rx_tready),
        .rx_frame_error   (rx_frame_error),
        .rx_overrun_error (rx_overrun_error)
`ifdef UART_MMIO_IRQ_EN
        ,
        .irq              (irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus_addr = a;
        bus_wdata = d;
        bus_wr_en = 1'b1;
        tick();
        bus_wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus_addr = a;
        bus_rd_en = 1'b1;
        tick();
        bus_rd_en = 1'b0;
        chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
        chk(tag, bus_rdata, exp);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_tdata = b;
        rx_tvalid = 1'b1;
        tick();
        rx_tvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #13;
        chk("rst_rx_tready", 32'(rx_tready), 32'd0);
        chk("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
        chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
`ifdef UART_MMIO_IRQ_EN
        chk("rst_irq", 32'(irq), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rel_rx_tready", 32'(rx_tready), 32'd1);

        // Single TX byte: visible next cycle, popped by ready
        tx_tready = 1'b1;
        bus_write(5'h0, 32'h41);
        chk("tx1_valid", 32'(tx_tvalid), 32'd1);
        chk("tx1_data", 32'(tx_tdata), 32'h41);
        tick();
        tx_tready = 1'b0;
        rd_chk("tx1_status", 5'h8, 32'h0000_000A);

        // Fill TX, 17th write dropped
        for (int i = 0; i < 17; i++) bus_write(5'h0, 32'h60 + i);
        rd_chk("txfull_status", 5'h8, 32'h0000_1049);
        bus_write(5'h8, 32'h40);
        rd_chk("txdrop_clr", 5'h8, 32'h0000_1009);

        // Write while full and popping: accepted, no drop
        chk("txhead0", 32'(tx_tdata), 32'h60);
        tx_tready = 1'b1;
        bus_write(5'h0, 32'h77);
        tx_tready = 1'b0;
        chk("txhead1", 32'(tx_tdata), 32'h61);
        rd_chk("txpoppush_status", 5'h8, 32'h0000_1009);
        bus_write(5'hC, 32'h4);
        chk("txflush_valid", 32'(tx_tvalid), 32'd0);
        rd_chk("txflush_status", 5'h8, 32'h0000_000A);

        // RX basic reads
        rx_push(8'h55);
        rx_push(8'hAA);
        rd_chk("rx_a", 5'h4, 32'h55);
        rd_chk("rx_b", 5'h4, 32'hAA);
        rd_chk("rx_empty", 5'h4, 32'h8000_0000);
        tick();
        chk("rvalid_pulse", 32'(bus_rvalid), 32'd0);
        chk("rdata_hold", bus_rdata, 32'h8000_0000);

        // RX full, overrun sticky, pop+push same cycle
        for (int i = 0; i < 16; i++) rx_push(8'h10 + 8'(i));
        chk("rxfull_ready", 32'(rx_tready), 32'd0);
        rd_chk("rxfull_status", 5'h8, 32'h0010_0006);
        rx_overrun_error = 1'b1;
        tick();
        rx_overrun_error = 1'b0;
        rd_chk("overrun_status", 5'h8, 32'h0010_0016);
        rx_tdata = 8'h99;
        rx_tvalid = 1'b1;
        rd_chk("rxfull_pop", 5'h4, 32'h10);
        rx_tvalid = 1'b0;
        rd_chk("rxfull_count", 5'h8, 32'h0010_0016);
        for (int i = 1; i < 16; i++) rd_chk("rx_drain", 5'h4, 32'h10 + i);
        rd_chk("rx_last", 5'h4, 32'h99);
        rd_chk("rx_drained_status", 5'h8, 32'h0000_001A);

        // Frame error, read-during-W1C returns pre-write, set beats clear
        rx_frame_error = 1'b1;
        tick();
        rx_frame_error = 1'b0;
        bus_addr = 5'h8;
        bus_wdata = 32'h30;
        bus_wr_en = 1'b1;
        bus_rd_en = 1'b1;
        tick();
        bus_wr_en = 1'b0;
        bus_rd_en = 1'b0;
        chk("rdwr_status", bus_rdata, 32'h0000_003A);
        rd_chk("w1c_status", 5'h8, 32'h0000_000A);
        rx_overrun_error = 1'b1;
        bus_write(5'h8, 32'h10);
        rx_overrun_error = 1'b0;
        rd_chk("setwins_status", 5'h8, 32'h0000_001A);
        bus_write(5'h8, 32'h70);
        rd_chk("clr_status", 5'h8, 32'h0000_000A);

        // Unmapped and write-only
        bus_write(5'h10, 32'h33);
        chk("unmapped_wr", 32'(tx_tvalid), 32'd0);
        rd_chk("unmapped_rd", 5'h18, 32'h0);
        rd_chk("txdata_rd", 5'h0, 32'h0);

`ifdef UART_MMIO_IRQ_EN
        bus_write(5'hC, 32'h3);
        rd_chk("ctrl_rd", 5'hC, 32'h3);
        bus_write(5'hC, 32'h1);
        tick();
        chk("irq_idle", 32'(irq), 32'd0);
        rx_push(8'h5A);
        tick();
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk("irq_rx", 5'h4, 32'h5A);
        tick();
        chk("irq_clr", 32'(irq), 32'd0);
`else
        bus_write(5'hC, 32'h3);
        rd_chk("ctrl_rd", 5'hC, 32'h0);
`endif

        // Asynchronous reset mid-cycle
        bus_write(5'h0, 32'h5A);
        chk("pre_rst_valid", 32'(tx_tvalid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_tx_tvalid", 32'(tx_tvalid), 32'd0);
        chk("arst_rx_tready", 32'(rx_tready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
